// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: one write-only data register with a
// single-entry holding buffer, and a read-only status register on a shared bus.
module mmio_uart_tx #(
    parameter logic [7:0] ADDR_DATA = 8'hFE,
    parameter logic [7:0] ADDR_STAT = 8'hFF,
    parameter int         CLKDIV    = 16
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] abus,
    inout  wire  [7:0] dbus,
    input  logic       mem_re_,
    input  logic       mem_we_,
    output logic       tx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    logic [1:0] state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] hold_reg, hold_next;
    logic       full_reg, full_next;
    logic       overrun_reg, overrun_next;
    logic       rd_pend_reg, rd_pend_next;
    logic       we_q_reg;
    logic       we_arm_reg;
    logic       tx_reg, tx_next;

    logic       load;
    logic       phase_end;
    logic       accept;
    logic       stat_rd;
    logic       busy;

    assign busy      = (state_reg != S_IDLE);
    assign phase_end = (cnt_reg == DIV_LAST);
    assign stat_rd   = !mem_re_ && (abus == ADDR_STAT);
    // we_arm_reg blocks a strobe that was already low when reset was released.
    assign accept    = !mem_we_ && we_q_reg && we_arm_reg && (abus == ADDR_DATA);

    assign dbus = stat_rd ? {5'b0, overrun_reg, full_reg, busy} : 8'hzz;
    assign tx   = tx_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        load         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (full_reg) begin
                    load         = 1'b1;
                    state_next   = S_START;
                    tx_next      = 1'b0;
                    cnt_next     = 8'd0;
                    bit_idx_next = 3'd0;
                end
            end
            S_START: begin
                if (phase_end) begin
                    cnt_next   = 8'd0;
                    state_next = S_DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DATA: begin
                if (phase_end) begin
                    cnt_next   = 8'd0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = 3'd0;
                        state_next   = S_STOP;
                        tx_next      = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_STOP: begin
                if (phase_end) begin
                    cnt_next = 8'd0;
                    // A held byte chains straight into the next start bit.
                    if (full_reg) begin
                        load       = 1'b1;
                        state_next = S_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
        if (load) begin
            shift_next = hold_reg;
        end
    end

    always_comb begin
        hold_next = hold_reg;
        full_next = full_reg;
        if (accept && (!full_reg || load)) begin
            hold_next = dbus;
            full_next = 1'b1;
        end else if (load) begin
            full_next = 1'b0;
        end
        overrun_next = overrun_reg;
        if (accept && full_reg && !load) begin
            overrun_next = 1'b1;
        end else if (mem_re_ && rd_pend_reg) begin
            overrun_next = 1'b0;
        end
        rd_pend_next = stat_rd || (rd_pend_reg && !mem_re_);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 8'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            hold_reg    <= 8'd0;
            full_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            rd_pend_reg <= 1'b0;
            we_q_reg    <= 1'b1;
            we_arm_reg  <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            hold_reg    <= hold_next;
            full_reg    <= full_next;
            overrun_reg <= overrun_next;
            rd_pend_reg <= rd_pend_next;
            we_q_reg    <= mem_we_;
            we_arm_reg  <= we_arm_reg | mem_we_;
            tx_reg      <= tx_next;
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter ADDR_DATA, default 8'hFE: bus address of the transmit data register (write-only).
REQ-002 Parameter ADDR_STAT, default 8'hFF: bus address of the status register (read-only).
REQ-003 Parameter CLKDIV, default 16: clock cycles per serial bit; legal range 2..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_  input  1  reset, asynchronous, active-low.
REQ-006 abus  input  8  shared address bus.
REQ-007 dbus  inout  8  shared data bus; driven only during a status read, high-Z otherwise.
REQ-008 mem_re_  input  1  bus read strobe, active-low.
REQ-009 mem_we_  input  1  bus write strobe, active-low.
REQ-010 tx  output  1  serial line: idle high, 8N1 framing, LSB first.

Function
REQ-011 Bus responder only; the block never drives abus, mem_re_ or mem_we_.
REQ-012 Write accept: at the rising edge where mem_we_=0, the previously sampled mem_we_=1, and abus==ADDR_DATA; exactly one accept per strobe assertion regardless of strobe length.
REQ-013 On accept with holding register empty (or emptying on that same edge): dbus is captured into the holding register and full is set to 1.
REQ-014 On accept with full=1 and no transfer on that edge: data is dropped, holding register is unchanged, and overrun is set to 1.
REQ-015 Status read: while mem_re_=0 and abus==ADDR_STAT, dbus = {5'b0, overrun, full, busy} combinationally; high-Z in all other cases.
REQ-016 overrun clears at the first edge where mem_re_ is sampled 1 after a status read; if an overrun event occurs on the same edge, set wins.
REQ-017 busy = 1 whenever the state machine is not IDLE.
REQ-018 States: IDLE, START, DATA, STOP. A 3-bit bit index and an 8-bit divide counter run in START, DATA and STOP.
REQ-019 IDLE -> START at the edge after full becomes 1: the shifter loads from the holding register, full clears, tx=0, and the counter resets.
REQ-020 START holds tx=0 for CLKDIV cycles, then moves to DATA.
REQ-021 DATA outputs shifter bit 0 for CLKDIV cycles per bit, shifting right 8 times with bit index 0..7, then moves to STOP.
REQ-022 STOP holds tx=1 for CLKDIV cycles. At the end of STOP, if full=1, the block loads the holding register and enters START on the same edge with no idle gap; otherwise it enters IDLE.
REQ-023 Frame length is exactly 10*CLKDIV cycles; first-byte latency is 1 cycle from accept to tx falling.
REQ-024 Counter and bit index wrap back to 0 only at defined phase ends; no other wrap-around is permitted.
REQ-025 tx is registered and glitch-free.

Reset
REQ-026 When rst_=0, immediately (asynchronously): state=IDLE, tx=1, full=0, overrun=0, busy=0, counter=0, bit index=0, shifter=0, sampled strobes=1, dbus high-Z.
REQ-027 Reset asserted mid-frame aborts the frame: tx returns high at once, and held data is discarded.
REQ-028 After rst_ deasserts, a strobe already held low is not accepted until it rises and falls again.

Verification
REQ-029 CLKDIV=4, write 8'hA5 to 8'hFE -> tx low 1 cycle after accept for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; 40 cycles total.
REQ-030 Write 8'h3C, then 8'hC3 during the 8'h3C frame -> status reads 8'h03 mid-frame; the two frames are back-to-back with no idle cycles; status reads 8'h00 afterwards.
REQ-031 Three writes during one frame -> the third is dropped; status reads 8'h07; after the read ends, status reads 8'h03; the dropped byte never appears on tx.
REQ-032 mem_we_ held low for 10 cycles at 8'hFE -> exactly one frame; a write to 8'h10 -> no frame and dbus stays high-Z; a read at 8'h10 -> dbus stays high-Z.
REQ-033 rst_ pulsed low mid-DATA -> tx=1 within the same cycle, status 8'h00, no residual frame after release.
